// File: rtl/implication_monitor.sv
// implication_monitor
//   Runtime checker for a registered data path. Watches the stage input I and
//   its registered output O and checks "I high implies O high DELAY cycles
//   later". Keeps saturating pass/fail counters, a sticky error flag, a
//   registered per-failure pulse and the cycle-counter value of the first
//   failure.
//
//   Optional build macro: MONITOR_ASSERT_EN adds simulation-only assertions
//   (a $error on every miss, and a DELAY range check at elaboration). The
//   hardware behaviour is identical with or without it.
//
//   Ports
//     CLK           clock, all state updates on posedge
//     RESET         synchronous active-high reset
//     EN            monitor enable
//     CLR           synchronous clear of counters, error and obligations
//     I             antecedent (stage input)
//     O             consequent (stage registered output)
//     pass_cnt      matured obligations satisfied (saturating)
//     fail_cnt      matured obligations violated (saturating)
//     error         sticky, set on first failure
//     fail_pulse    one-cycle registered pulse per failure
//     first_fail_ts cyc_cnt value at the first failure
//     state         00 DISABLED, 01 MONITOR, 10 FAILED
//
//   state    | meaning
//   DISABLED | EN low (or just cleared with EN low); no checks, pend flushed
//   MONITOR  | checking, no failure seen since reset/CLR
//   FAILED   | at least one failure seen; checking and counting continue
module implication_monitor #(
  parameter int DELAY = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             CLR,
  input  logic             I,
  input  logic             O,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             error,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] first_fail_ts,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    DISABLED = 2'b00,
    MONITOR  = 2'b01,
    FAILED   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_r;
  state_t           state_n;
  logic [DELAY-1:0] pend;
  logic [DELAY-1:0] pend_next;
  logic [CNT_W-1:0] cyc_cnt;
  logic             matured;
  logic             hit;
  logic             miss;

  // pend[0] holds I from the previous enabled cycle, so pend[DELAY-1] is the
  // antecedent that is due to be checked against O in the current cycle.
  assign matured = pend[DELAY-1];
  assign state   = state_r;

  always_comb begin
    pend_next    = pend << 1;
    pend_next[0] = I;
  end

  always_comb begin
    state_n = state_r;
    hit     = 1'b0;
    miss    = 1'b0;
    if (CLR) begin
      state_n = EN ? MONITOR : DISABLED;
    end else if (!EN) begin
      state_n = DISABLED;
    end else begin
      if (state_r != DISABLED) begin
        hit  = matured & O;
        miss = matured & ~O;
      end
      case (state_r)
        DISABLED: state_n = MONITOR;
        MONITOR:  if (miss) state_n = FAILED;
        FAILED:   state_n = FAILED;
        default:  state_n = DISABLED;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_r <= DISABLED;
    else       state_r <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (RESET || CLR) begin
      pend          <= '0;
      cyc_cnt       <= '0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      first_fail_ts <= '0;
      error         <= 1'b0;
      fail_pulse    <= 1'b0;
    end else if (!EN) begin
      // Flush so no stale obligation matures after re-enable.
      pend       <= '0;
      fail_pulse <= 1'b0;
    end else begin
      pend       <= pend_next;
      fail_pulse <= miss;
      if (cyc_cnt != CNT_MAX) cyc_cnt <= cyc_cnt + CNT_ONE;
      if (hit && pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
      if (miss && fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
      if (miss && !error) begin
        first_fail_ts <= cyc_cnt;
        error         <= 1'b1;
      end
    end
  end

`ifdef MONITOR_ASSERT_EN
  if (DELAY < 1 || DELAY > 15) begin : g_delay_range
    $error("implication_monitor: DELAY=%0d outside 1..15", DELAY);
  end

  always @(posedge CLK) begin
    if (!RESET) begin
      assert (!miss)
      else $error("implication_monitor: I did not imply O at cyc_cnt=%0d", cyc_cnt);
    end
  end
`endif

endmodule
